// File: rtl/mm_cond_sub_if.sv
// Word-serial stream bundle for mm_cond_sub: operand words go in, result words come out.
// The master side issues start/operand words. The slave side is the conditional subtractor.
interface mm_cond_sub_if #(
    parameter int K = 128
);
    logic         start;
    logic         sub_en;
    logic [K-1:0] t_word;
    logic [K-1:0] m_word;
    logic         in_valid;
    logic         t_top;
    logic [K-1:0] r_word;
    logic         r_valid;
    logic         r_last;
    logic         busy;
    logic         err;

    modport master (
        output start, sub_en, t_word, m_word, in_valid, t_top,
        input  r_word, r_valid, r_last, busy, err
    );

    modport slave (
        input  start, sub_en, t_word, m_word, in_valid, t_top,
        output r_word, r_valid, r_last, busy, err
    );
endinterface

// File: rtl/mm_cond_sub.sv
// Word-serial conditional subtract (Montgomery final step).
// The block computes R = (sub_en && {t_top,T} >= M) ? {t_top,T} - M : T.
// While operands stream in LSW first, it stores both T and T-M word by word, with one K-bit
// subtract per cycle. Once the final borrow is known, it streams out whichever copy is the
// result.
module mm_cond_sub #(
    parameter int K = 128,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mm_cond_sub_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        OUT
    } state_t;

    state_t         state;
    logic           busy_q;
    logic [IDX_W-1:0] idx;
    logic           borrow;
    logic           sel;
    logic           sub_en_q;
    logic           issue_done;

    // T and D = T - M copies, one entry per word.
    logic [K-1:0]   t_buf [N];
    logic [K-1:0]   d_buf [N];

    // Read stage between the buffers and the output register.
    logic [K-1:0]   rd_data;
    logic           rd_valid;
    logic           rd_last;

    logic [K-1:0]   r_word_q;
    logic           r_valid_q;
    logic           r_last_q;
    logic           err_q;

    logic [K:0]     diff_ext;
    logic           last_idx;
    logic           accept;
    logic           issue;

    // Subtract one word: T word minus M word minus the incoming borrow. Bit K is the outgoing borrow.
    // NOTE: this block assigns diff_ext on every path, so no latch is inferred.
    always_comb begin
        diff_ext = {1'b0, bus.t_word} - {1'b0, bus.m_word} - {{K{1'b0}}, borrow};
    end

    assign last_idx = (idx == IDX_W'(N - 1));
    assign accept   = (state == LOAD) && bus.in_valid;
    assign issue    = (state == OUT) && !issue_done;

    // Buffer writes during LOAD and synchronous buffer reads during OUT.
    // NOTE: buffer contents need no reset. The block never reads an entry before writing it in the same operation, and leaving out the reset lets the tools map these arrays to RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            t_buf[idx] <= bus.t_word;
            d_buf[idx] <= diff_ext[K-1:0];
        end
        if (issue) begin
            rd_data <= sel ? d_buf[idx] : t_buf[idx];
        end
    end

    // Control FSM, borrow chain, read and output pipeline, and protocol error pulse.
    // NOTE: all state here uses non-blocking assignments, so every branch reads the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            idx        <= '0;
            borrow     <= 1'b0;
            sel        <= 1'b0;
            sub_en_q   <= 1'b0;
            issue_done <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            r_word_q   <= '0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // A start while busy, or an input word outside LOAD, is dropped and flagged.
            err_q     <= (bus.start && (state != IDLE)) || (bus.in_valid && (state != LOAD));

            rd_valid  <= 1'b0;
            r_valid_q <= rd_valid;
            r_last_q  <= rd_valid && rd_last;
            r_word_q  <= rd_valid ? rd_data : '0;

            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sub_en_q   <= bus.sub_en;
                        idx        <= '0;
                        borrow     <= 1'b0;
                        issue_done <= 1'b0;
                        state      <= LOAD;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        borrow <= diff_ext[K];
                        if (last_idx) begin
                            // The final borrow clear (or the extra top bit) means {t_top,T} >= M.
                            sel   <= sub_en_q & (bus.t_top | ~diff_ext[K]);
                            idx   <= '0;
                            state <= OUT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (!issue_done) begin
                        rd_valid <= 1'b1;
                        rd_last  <= last_idx;
                        if (last_idx) begin
                            issue_done <= 1'b1;
                            idx        <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (r_last_q) begin
                        // The last word has been presented, so the block is free again.
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r_word  = r_word_q;
    assign bus.r_valid = r_valid_q;
    assign bus.r_last  = r_last_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_mm_cond_sub.sv
// Self-checking bench for mm_cond_sub with K=8, N=4.
// The bench computes expected results from whole-operand arithmetic and checks output timing against the stream rules.
module tb_mm_cond_sub;
    localparam int K = 8;
    localparam int N = 4;
    localparam int W = K * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mm_cond_sub_if #(.K(K)) bus ();

    mm_cond_sub #(.K(K), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference result computed on whole operands.
    function automatic logic [W-1:0] ref_r(input logic [W-1:0] t, input logic [W-1:0] m,
                                           input logic tt, input logic se);
        logic [W:0] full;
        full = {tt, t};
        if (se && (full >= {1'b0, m})) return W'(full - {1'b0, m});
        return t;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.start    = 1'b0;
        bus.sub_en   = 1'b0;
        bus.in_valid = 1'b0;
        bus.t_top    = 1'b0;
        bus.t_word   = '0;
        bus.m_word   = '0;
    endtask

    // One complete operation. An idle cycle follows word i when gaps[i] is set.
    // A start pulse is driven after output cycle inject_at when inject_at > 0.
    task automatic run_op(input string name, input logic [W-1:0] t, input logic [W-1:0] m,
                          input logic tt, input logic se, input logic [N-1:0] gaps,
                          input int inject_at);
        logic [W-1:0] exp_r;
        logic [W-1:0] got;
        int nv, first_c, prev_c, last_c, bad_contig, bad_err;
        exp_r = ref_r(t, m, tt, se);
        bus.start  = 1'b1;
        bus.sub_en = se;
        tick();
        bus.start  = 1'b0;
        bus.sub_en = 1'($urandom);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b want 1", name, bus.busy);
        end
        for (int i = 0; i < N; i++) begin
            bus.in_valid = 1'b1;
            bus.t_word   = t[i*K +: K];
            bus.m_word   = m[i*K +: K];
            bus.t_top    = (i == N - 1) ? tt : 1'($urandom);
            tick();
            if (gaps[i] && (i != N - 1)) begin
                bus.in_valid = 1'b0;
                bus.t_word   = K'($urandom);
                bus.m_word   = K'($urandom);
                tick();
            end
        end
        bus.in_valid = 1'b0;
        bus.t_top    = 1'b0;
        got = '0; nv = 0; first_c = -1; prev_c = -1; last_c = -1;
        bad_contig = 0; bad_err = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.r_valid === 1'b1) begin
                if (nv < N) got[nv*K +: K] = bus.r_word;
                if (first_c < 0) first_c = c;
                else if (c != prev_c + 1) bad_contig++;
                prev_c = c;
                nv++;
                if (bus.r_last === 1'b1) last_c = c;
            end else if (bus.r_last !== 1'b0) begin
                bad_contig++;
            end
            if (bus.err !== ((inject_at > 0) && (c == inject_at + 1))) bad_err++;
            bus.start  = (c == inject_at);
            bus.sub_en = 1'($urandom);
        end
        bus.start = 1'b0;
        checks++;
        if (got !== exp_r) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, got, exp_r);
        end
        checks++;
        if (nv != N) begin
            errors++;
            $display("FAIL %s word_count: got %0d want %0d", name, nv, N);
        end
        checks++;
        if (first_c != 2) begin
            errors++;
            $display("FAIL %s first_valid_latency: got %0d want 2", name, first_c);
        end
        checks++;
        if (last_c != N + 1) begin
            errors++;
            $display("FAIL %s r_last_cycle: got %0d want %0d", name, last_c, N + 1);
        end
        checks++;
        if (bad_contig != 0) begin
            errors++;
            $display("FAIL %s contiguity: got %0d gaps want 0", name, bad_contig);
        end
        checks++;
        if (bad_err != 0) begin
            errors++;
            $display("FAIL %s err_pattern: got %0d bad cycles want 0", name, bad_err);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_op: got %b want 0", name, bus.busy);
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({bus.busy, bus.r_valid, bus.r_last, bus.err, bus.r_word} !== '0) begin
            errors++;
            $display("FAIL %s reset_outputs: got busy=%b r_valid=%b r_last=%b err=%b r_word=%h want all 0",
                     name, bus.busy, bus.r_valid, bus.r_last, bus.err, bus.r_word);
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check_quiet("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_quiet("post_reset");
    endtask

    task automatic test_directed;
        run_op("sub_basic", 32'h01020304, 32'h01020303, 1'b0, 1'b1, 4'b0000, 0);
        run_op("t_lt_m", 32'h01020303, 32'h01020304, 1'b0, 1'b1, 4'b0000, 0);
        run_op("t_eq_m", 32'h01020304, 32'h01020304, 1'b0, 1'b1, 4'b0000, 0);
        run_op("t_top", 32'h00000005, 32'hFFFFFFFB, 1'b1, 1'b1, 4'b0000, 0);
        run_op("pass", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'b0000, 0);
        run_op("pass_gaps", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'b1111, 0);
    endtask

    task automatic test_reset_mid_load;
        bus.start  = 1'b1;
        bus.sub_en = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.t_word   = K'($urandom);
            bus.m_word   = K'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_quiet("reset_mid_load");
        tick();
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (bus.r_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
            end
            checks++;
            if (seen != 0) begin
                errors++;
                $display("FAIL reset_mid_load stray_activity: got %0d cycles want 0", seen);
            end
        end
        run_op("after_reset", 32'h01020304, 32'h01020303, 1'b0, 1'b1, 4'b0000, 0);
    endtask

    task automatic test_reset_mid_out;
        bus.start  = 1'b1;
        bus.sub_en = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.in_valid = 1'b1;
            bus.t_word   = 8'hA5;
            bus.m_word   = 8'h00;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.r_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_out pre_valid: got %b want 1", bus.r_valid);
        end
        #2 rst_n = 1'b0;
        #1 check_quiet("reset_mid_out");
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_quiet("reset_mid_out_after");
    endtask

    task automatic test_protocol_err;
        bus.in_valid = 1'b1;
        bus.t_word   = 8'h77;
        bus.m_word   = 8'h11;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL idle_in_valid err_pulse: got %b want 1", bus.err);
        end
        tick();
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_valid err_clear: got %b want 0", bus.err);
        end
        run_op("start_in_out", 32'h01020304, 32'h01020303, 1'b0, 1'b1, 4'b0000, 3);
    endtask

    task automatic test_random;
        logic [W-1:0] t, m;
        for (int it = 0; it < 24; it++) begin
            t = W'($urandom);
            case ($urandom_range(0, 3))
                0: m = W'($urandom);
                1: m = t;
                2: m = t + 1;
                default: m = t - 1;
            endcase
            run_op($sformatf("rand%0d", it), t, m, ($urandom_range(0, 3) == 0),
                   1'($urandom), N'($urandom), 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_load();
        test_reset_mid_out();
        test_protocol_err();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
